mem_arbiter: RTL and testbench

Two-port arbiter and sequencer for the shared 256x8 RAM (8-bit address, 24-bit tri-state bus, 1–3 byte transfers).
- Requester 0 is instruction fetch (read-only); requester 1 is data load/store.
- Latches one request, drives the RAM control/address/bus for exactly one access cycle, captures read data, and returns a one-cycle ack.
- Sits between the control unit and the RAM instance.

---
 rtl/mem_arbiter.sv | 150 +++++++++++++++
 tb/tb_mem_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port arbiter/sequencer for the shared 256x8 RAM: fetch (read-only) and data (load/store).
// One latched request per pass through IDLE -> ACCESS -> RESP, with a registered one-cycle ack.
module mem_arbiter #(
  parameter bit FETCH_FIRST = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_if_req,
  input  logic [7:0]  i_if_address,
  input  logic [1:0]  i_if_width,
  output logic        o_if_ack,
  output logic [23:0] o_if_rdata,
  input  logic        i_d_req,
  input  logic        i_d_write,
  input  logic [7:0]  i_d_address,
  input  logic [1:0]  i_d_width,
  input  logic [23:0] i_d_wdata,
  output logic        o_d_ack,
  output logic [23:0] o_d_rdata,
  output logic [1:0]  o_mem_read,
  output logic [1:0]  o_mem_write,
  output logic [7:0]  o_mem_address,
  inout  wire  [23:0] io_bus,
  output logic        o_busy
);

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 24;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t          state;
  logic            fav_data;
  logic            own_data;
  logic            lat_write;
  logic [1:0]      lat_width;
  logic [DW-1:0]   lat_wdata;
  logic            bus_oe;
  logic [1:0]      mem_read;
  logic [1:0]      mem_write;
  logic [AW-1:0]   mem_address;
  logic            if_ack;
  logic            d_ack;
  logic [DW-1:0]   if_rdata;
  logic [DW-1:0]   d_rdata;
  logic            busy;

  logic            grant_if;
  logic            grant_d;
  logic            sel_write;
  logic [1:0]      sel_width;
  logic [AW-1:0]   sel_addr;

  function automatic logic [DW-1:0] width_mask(input logic [1:0] w);
    case (w)
      2'd1:    width_mask = 24'h0000FF;
      2'd2:    width_mask = 24'h00FFFF;
      2'd3:    width_mask = 24'hFFFFFF;
      default: width_mask = 24'h000000;
    endcase
  endfunction

  // Grant selection: on contention the favoured side wins, otherwise whoever asks.
  always_comb begin
    grant_if  = 1'b0;
    grant_d   = 1'b0;
    if (i_if_req && i_d_req) begin
      grant_d  = fav_data;
      grant_if = ~fav_data;
    end else begin
      grant_if = i_if_req;
      grant_d  = i_d_req;
    end
    sel_write = grant_d & i_d_write;
    sel_width = grant_d ? i_d_width : i_if_width;
    sel_addr  = grant_d ? i_d_address : i_if_address;
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state       <= IDLE;
      fav_data    <= ~FETCH_FIRST;
      own_data    <= 1'b0;
      lat_write   <= 1'b0;
      lat_width   <= 2'd0;
      lat_wdata   <= '0;
      bus_oe      <= 1'b0;
      mem_read    <= 2'd0;
      mem_write   <= 2'd0;
      mem_address <= '0;
      if_ack      <= 1'b0;
      d_ack       <= 1'b0;
      if_rdata    <= '0;
      d_rdata     <= '0;
      busy        <= 1'b0;
    end else begin
      if_ack <= 1'b0;
      d_ack  <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_if || grant_d) begin
            state       <= ACCESS;
            busy        <= 1'b1;
            own_data    <= grant_d;
            lat_write   <= sel_write;
            lat_width   <= sel_width;
            lat_wdata   <= i_d_wdata;
            mem_address <= sel_addr;
            mem_read    <= sel_write ? 2'd0 : sel_width;
            mem_write   <= sel_write ? sel_width : 2'd0;
            bus_oe      <= sel_write && (sel_width != 2'd0);
            if (i_if_req && i_d_req) fav_data <= ~fav_data;
          end
        end
        ACCESS: begin
          state     <= RESP;
          mem_read  <= 2'd0;
          mem_write <= 2'd0;
          bus_oe    <= 1'b0;
          // Bytes beyond the width are forced to zero, so width 0 yields all zeros.
          if (!lat_write) begin
            if (own_data) d_rdata  <= io_bus & width_mask(lat_width);
            else          if_rdata <= io_bus & width_mask(lat_width);
          end
          if (own_data) d_ack  <= 1'b1;
          else          if_ack <= 1'b1;
        end
        RESP: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign io_bus        = bus_oe ? lat_wdata : 24'hzzzzzz;
  assign o_mem_read    = mem_read;
  assign o_mem_write   = mem_write;
  assign o_mem_address = mem_address;
  assign o_if_ack      = if_ack;
  assign o_d_ack       = d_ack;
  assign o_if_rdata    = if_rdata;
  assign o_d_rdata     = d_rdata;
  assign o_busy        = busy;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: RAM model on the tri-state bus, directed vector table,
// hand-written contention/reset sequences and random traffic against a transaction model.
module tb_mem_arbiter;

  localparam bit FETCH_FIRST = 1'b1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0;
  logic [7:0]  if_addr = 8'h00;
  logic [1:0]  if_width = 2'd0;
  logic        d_req = 1'b0;
  logic        d_write = 1'b0;
  logic [7:0]  d_addr = 8'h00;
  logic [1:0]  d_width = 2'd0;
  logic [23:0] d_wdata = 24'h0;
  logic        o_if_ack, o_d_ack, o_busy;
  logic [23:0] o_if_rdata, o_d_rdata;
  logic [1:0]  o_mem_read, o_mem_write;
  logic [7:0]  o_mem_address;
  wire  [23:0] io_bus;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.FETCH_FIRST(FETCH_FIRST)) dut (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_if_req(if_req), .i_if_address(if_addr), .i_if_width(if_width),
    .o_if_ack(o_if_ack), .o_if_rdata(o_if_rdata),
    .i_d_req(d_req), .i_d_write(d_write), .i_d_address(d_addr), .i_d_width(d_width),
    .i_d_wdata(d_wdata), .o_d_ack(o_d_ack), .o_d_rdata(o_d_rdata),
    .o_mem_read(o_mem_read), .o_mem_write(o_mem_write), .o_mem_address(o_mem_address),
    .io_bus(io_bus), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] init_byte(input logic [7:0] a);
    if (a == 8'h02)      init_byte = 8'h01;
    else if (a == 8'h03) init_byte = 8'h20;
    else                 init_byte = a;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // RAM: drives all three bytes on a read so the arbiter's width masking is exercised.
  logic [7:0] ram [256];
  bit ram_ready = 1'b0;
  assign io_bus = (o_mem_read != 2'd0) ?
      {ram[8'(o_mem_address + 8'd2)], ram[8'(o_mem_address + 8'd1)], ram[o_mem_address]} : 24'hzzzzzz;

  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < 256; i++) ram[i] <= init_byte(8'(i));
      ram_ready <= 1'b1;
    end else if (o_mem_write != 2'd0) begin
      for (int i = 0; i < 3; i++)
        if (i < int'(o_mem_write)) ram[8'(o_mem_address + 8'(i))] <= io_bus[8*i +: 8];
    end
  end

  // Inputs as seen by the DUT at each rising edge.
  logic        s_rst_n, s_if_req, s_d_req, s_d_write;
  logic [7:0]  s_if_addr, s_d_addr;
  logic [1:0]  s_if_width, s_d_width;
  logic [23:0] s_d_wdata;
  always @(posedge clk) begin
    s_rst_n <= rst_n; s_if_req <= if_req; s_if_addr <= if_addr; s_if_width <= if_width;
    s_d_req <= d_req; s_d_write <= d_write; s_d_addr <= d_addr; s_d_width <= d_width;
    s_d_wdata <= d_wdata;
  end

  // Transaction-level reference: each grant occupies three cycles (access, ack, recover).
  logic [7:0]  ref_mem [256];
  int          ph;
  bit          t_side, t_write, fav_d, m_rst, picked;
  logic [7:0]  t_addr;
  logic [1:0]  t_width;
  logic [23:0] t_wdata, m_if_rdata, m_d_rdata;

  function automatic logic [23:0] ref_read(input logic [7:0] a, input logic [1:0] w);
    logic [23:0] r = 24'h0;
    for (int i = 0; i < int'(w); i++) r[8*i +: 8] = ref_mem[8'(a + 8'(i))];
    return r;
  endfunction

  initial begin
    int ones;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_byte(8'(i));
    ph = 0; fav_d = ~FETCH_FIRST; m_if_rdata = 0; m_d_rdata = 0; m_rst = 0;
    t_side = 0; t_write = 0; t_addr = 0; t_width = 0; t_wdata = 0;
    forever begin
      @(negedge clk);
      if (!s_rst_n) begin
        if (ph == 1 && t_write)
          for (int i = 0; i < int'(t_width); i++) ref_mem[8'(t_addr + 8'(i))] = t_wdata[8*i +: 8];
        ph = 0; fav_d = ~FETCH_FIRST; m_if_rdata = 0; m_d_rdata = 0; m_rst = 1;
      end else begin
        m_rst = 0;
        if (ph == 0) begin
          picked = 1;
          if (s_if_req && s_d_req) begin t_side = fav_d; fav_d = ~fav_d; end
          else if (s_if_req) t_side = 0;
          else if (s_d_req)  t_side = 1;
          else picked = 0;
          if (picked) begin
            t_write = t_side && s_d_write;
            t_addr  = t_side ? s_d_addr : s_if_addr;
            t_width = t_side ? s_d_width : s_if_width;
            t_wdata = s_d_wdata;
            ph = 1;
          end
        end else if (ph == 1) begin
          if (t_write)
            for (int i = 0; i < int'(t_width); i++) ref_mem[8'(t_addr + 8'(i))] = t_wdata[8*i +: 8];
          else if (t_side) m_d_rdata = ref_read(t_addr, t_width);
          else             m_if_rdata = ref_read(t_addr, t_width);
          ph = 2;
        end else ph = 0;
      end
      chk("m_if_ack", 32'(o_if_ack), 32'(ph == 2 && !t_side));
      chk("m_d_ack", 32'(o_d_ack), 32'(ph == 2 && t_side));
      chk("m_if_rdata", 32'(o_if_rdata), 32'(m_if_rdata));
      chk("m_d_rdata", 32'(o_d_rdata), 32'(m_d_rdata));
      chk("m_mem_read", 32'(o_mem_read), 32'((ph == 1 && !t_write) ? t_width : 2'd0));
      chk("m_mem_write", 32'(o_mem_write), 32'((ph == 1 && t_write) ? t_width : 2'd0));
      chk("m_busy", 32'(o_busy), 32'(ph != 0));
      if (ph == 1 || m_rst) chk("m_mem_addr", 32'(o_mem_address), 32'(ph == 1 ? t_addr : 8'h00));
      if (ph == 1 && t_write && t_width != 2'd0) chk("m_bus_wdata", 32'(io_bus), 32'(t_wdata));
      else if (!(ph == 1 && !t_write && t_width != 2'd0)) begin
        ones = 0;
        for (int i = 0; i < 24; i++) if (io_bus[i] === 1'b1) ones++;
        chk("m_bus_released", 32'(ones), 32'd0);
      end
    end
  end

  // Directed single-transaction vectors; exp is the owner's rdata after the ack.
  typedef struct {
    bit          side;
    bit          write;
    logic [7:0]  addr;
    logic [1:0]  width;
    logic [23:0] wdata;
    logic [23:0] exp;
  } vec_t;
  vec_t vecs[12];

  task automatic run_vec(input vec_t v);
    @(negedge clk);
    if (v.side) begin
      d_req = 1; d_write = v.write; d_addr = v.addr; d_width = v.width; d_wdata = v.wdata;
    end else begin
      if_req = 1; if_addr = v.addr; if_width = v.width;
    end
    @(negedge clk);
    chk("v_mem_read", 32'(o_mem_read), 32'(v.write ? 2'd0 : v.width));
    chk("v_mem_write", 32'(o_mem_write), 32'(v.write ? v.width : 2'd0));
    chk("v_mem_addr", 32'(o_mem_address), 32'(v.addr));
    chk("v_busy_access", 32'(o_busy), 32'd1);
    if (v.write && v.width != 2'd0) chk("v_bus_wdata", 32'(io_bus), 32'(v.wdata));
    @(negedge clk);
    chk("v_if_ack", 32'(o_if_ack), 32'(!v.side));
    chk("v_d_ack", 32'(o_d_ack), 32'(v.side));
    chk("v_rdata", 32'(v.side ? o_d_rdata : o_if_rdata), 32'(v.exp));
    chk("v_busy_resp", 32'(o_busy), 32'd1);
    if_req = 0; d_req = 0;
    @(negedge clk);
    chk("v_ack_clear", 32'({o_if_ack, o_d_ack}), 32'd0);
    chk("v_busy_idle", 32'(o_busy), 32'd0);
  endtask

  initial begin
    int diffs;
    vecs[0]  = '{1'b0, 1'b0, 8'h02, 2'd2, 24'h000000, 24'h002001};
    vecs[1]  = '{1'b0, 1'b0, 8'h02, 2'd3, 24'h000000, 24'h042001};
    vecs[2]  = '{1'b0, 1'b0, 8'h02, 2'd1, 24'h000000, 24'h000001};
    vecs[3]  = '{1'b1, 1'b1, 8'h40, 2'd3, 24'hA5B6C7, 24'h000000};
    vecs[4]  = '{1'b1, 1'b0, 8'h40, 2'd3, 24'h000000, 24'hA5B6C7};
    vecs[5]  = '{1'b1, 1'b0, 8'h41, 2'd2, 24'h000000, 24'h00A5B6};
    vecs[6]  = '{1'b1, 1'b0, 8'h40, 2'd0, 24'h000000, 24'h000000};
    vecs[7]  = '{1'b0, 1'b0, 8'hFE, 2'd3, 24'h000000, 24'h00FFFE};
    vecs[8]  = '{1'b1, 1'b1, 8'hFF, 2'd2, 24'h123456, 24'h000000};
    vecs[9]  = '{1'b1, 1'b0, 8'hFF, 2'd3, 24'h000000, 24'h013456};
    vecs[10] = '{1'b1, 1'b1, 8'h50, 2'd0, 24'hFFFFFF, 24'h013456};
    vecs[11] = '{1'b1, 1'b0, 8'h50, 2'd1, 24'h000000, 24'h000050};

    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_rdata", 32'({o_if_rdata, o_d_rdata} != 48'h0), 32'd0);
    rst_n = 1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Contention from reset: fetch, data, fetch, data with acks every third cycle.
    @(negedge clk);
    rst_n = 0;
    if_req = 1; if_addr = 8'h02; if_width = 2'd1;
    d_req = 1; d_write = 0; d_addr = 8'h40; d_width = 2'd1;
    @(negedge clk);
    rst_n = 1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("cont_if_ack", 32'(o_if_ack), 32'(k == 1 || k == 7));
      chk("cont_d_ack", 32'(o_d_ack), 32'(k == 4 || k == 10));
    end
    chk("cont_if_rdata", 32'(o_if_rdata), 32'h000001);
    chk("cont_d_rdata", 32'(o_d_rdata), 32'h0000C7);
    if_req = 0; d_req = 0;
    repeat (3) @(negedge clk);

    // Reset landing on the closing edge of a store access.
    d_req = 1; d_write = 1; d_addr = 8'h10; d_width = 2'd1; d_wdata = 24'h00005A;
    @(negedge clk);
    chk("rs_mem_write", 32'(o_mem_write), 32'd1);
    chk("rs_bus", 32'(io_bus[7:0]), 32'h5A);
    rst_n = 0; d_req = 0;
    @(negedge clk);
    chk("rs_ram", 32'(ram[8'h10]), 32'h5A);
    chk("rs_d_ack", 32'(o_d_ack), 32'd0);
    chk("rs_busy", 32'(o_busy), 32'd0);
    chk("rs_codes", 32'({o_mem_read, o_mem_write}), 32'd0);
    chk("rs_d_rdata", 32'(o_d_rdata), 32'd0);
    rst_n = 1;
    @(negedge clk);
    chk("rs_no_late_ack", 32'(o_d_ack), 32'd0);

    // Random mixed traffic; protocol and data are checked every cycle by the model.
    repeat (3000) begin
      @(negedge clk);
      if (!rst_n) rst_n = 1;
      else if ($urandom_range(0, 199) == 0) begin
        rst_n = 0; if_req = 0; d_req = 0;
      end else begin
        if (if_req && o_if_ack) if_req = ($urandom_range(0, 2) == 0);
        else if (!if_req) if_req = ($urandom_range(0, 1) == 1);
        if (d_req && o_d_ack) d_req = ($urandom_range(0, 2) == 0);
        else if (!d_req) d_req = ($urandom_range(0, 1) == 1);
        if ($urandom_range(0, 1) == 1) begin
          if_addr = 8'(8'hF8 + 8'($urandom_range(0, 15)));
          if_width = 2'($urandom_range(0, 3));
        end
        if ($urandom_range(0, 1) == 1) begin
          d_write = 1'($urandom_range(0, 1));
          d_addr = 8'(8'hF8 + 8'($urandom_range(0, 15)));
          d_width = 2'($urandom_range(0, 3));
          d_wdata = 24'($urandom);
        end
      end
    end
    @(negedge clk);
    rst_n = 1; if_req = 0; d_req = 0;
    repeat (5) @(negedge clk);
    diffs = 0;
    for (int i = 0; i < 256; i++) if (ram[i] !== ref_mem[i]) diffs++;
    chk("ram_image", 32'(diffs), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
